// File: rtl/sprite_anim_fetch_pkg.sv
// Shared definitions for the sprite fetch path: sheet geometry defaults,
// colour width, transparency key and the per-player animation state encoding.
package sprite_pkg;

  // Default sprite-sheet geometry
  localparam int SPR_W_DEF    = 48;
  localparam int SPR_H_DEF    = 67;
  localparam int SHEET_W_DEF  = 816;
  localparam int N_STATES_DEF = 16;
  localparam int N_FRAMES_DEF = 4;

  // Colour format
  localparam int              CLR_W          = 12;
  localparam logic [CLR_W-1:0] TRANSP_KEY_DEF = 12'hF0F;

  // Animation state of one player
  typedef enum logic [1:0] {
    ANIM_ALIVE = 2'd0,
    ANIM_DYING = 2'd1,
    ANIM_DEAD  = 2'd2
  } anim_state_e;

  // Index width for a count of n items (at least one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_fetch_if.sv
// Pixel request / pixel response bus between the VGA scanner (master)
// and the sprite fetcher (slave).
interface sprite_anim_fetch_if
  import sprite_pkg::*;
#(
  parameter int PW = 1
);

  logic             req_valid;
  logic [PW-1:0]    req_player;
  logic [5:0]       req_x;
  logic [6:0]       req_y;
  logic             pix_valid;
  logic [CLR_W-1:0] pix_clr;
  logic             pix_transp;

  modport master (
    output req_valid, req_player, req_x, req_y,
    input  pix_valid, pix_clr, pix_transp
  );

  modport slave (
    input  req_valid, req_player, req_x, req_y,
    output pix_valid, pix_clr, pix_transp
  );

endinterface

// File: rtl/sprite_anim_ctr.sv
// Per-player animation frame counter: frame divider, ALIVE/DYING/DEAD
// state machine and edge detection on the pose and is_dead inputs.
module sprite_anim_ctr
  import sprite_pkg::*;
#(
  parameter int N_FRAMES  = N_FRAMES_DEF,
  parameter int FRAME_DIV = 8,
  parameter int FW        = idx_w(N_FRAMES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_frame_tick,
  input  logic [3:0]    i_state,
  input  logic          i_is_dead,
  output logic [FW-1:0] o_frame,
  output logic          o_dead_done
);

  localparam int             DW         = idx_w(FRAME_DIV);
  localparam logic [DW-1:0]  DIV_LAST   = DW'(FRAME_DIV - 1);
  localparam logic [FW-1:0]  FRAME_LAST = FW'(N_FRAMES - 1);

  anim_state_e   r_anim;
  logic [DW-1:0] r_div;
  logic [FW-1:0] r_frame;
  logic          r_dead_done;
  logic [3:0]    r_state_prev;
  logic          r_dead_prev;

  logic          w_wrap;
  logic [FW-1:0] w_frame_inc;

  assign w_wrap      = i_frame_tick && (r_div == DIV_LAST);
  assign w_frame_inc = (r_frame == FRAME_LAST) ? '0 : r_frame + FW'(1);

  // Animation FSM: is_dead edges and pose changes restart the animation and
  // take priority over a frame step landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_anim       <= ANIM_ALIVE;
      r_div        <= '0;
      r_frame      <= '0;
      r_dead_done  <= 1'b0;
      r_state_prev <= '0;
      r_dead_prev  <= 1'b0;
    end else begin
      r_state_prev <= i_state;
      r_dead_prev  <= i_is_dead;
      if (i_is_dead && !r_dead_prev) begin
        r_anim      <= ANIM_DYING;
        r_div       <= '0;
        r_frame     <= '0;
        r_dead_done <= 1'b0;
      end else if (!i_is_dead && r_dead_prev) begin
        r_anim      <= ANIM_ALIVE;
        r_div       <= '0;
        r_frame     <= '0;
        r_dead_done <= 1'b0;
      end else begin
        case (r_anim)
          ANIM_ALIVE: begin
            if (i_state != r_state_prev) begin
              r_div   <= '0;
              r_frame <= '0;
            end else if (i_frame_tick) begin
              if (w_wrap) begin
                r_div   <= '0;
                r_frame <= w_frame_inc;
              end else begin
                r_div <= r_div + DW'(1);
              end
            end
          end
          ANIM_DYING: begin
            // A single-frame animation is already on its last frame
            if (r_frame == FRAME_LAST) begin
              r_anim      <= ANIM_DEAD;
              r_dead_done <= 1'b1;
            end else if (i_frame_tick) begin
              if (w_wrap) begin
                r_div   <= '0;
                r_frame <= r_frame + FW'(1);
                if ((r_frame + FW'(1)) == FRAME_LAST) begin
                  r_anim      <= ANIM_DEAD;
                  r_dead_done <= 1'b1;
                end
              end else begin
                r_div <= r_div + DW'(1);
              end
            end
          end
          ANIM_DEAD: begin
            r_dead_done <= 1'b1;
          end
          default: begin
            r_anim <= ANIM_ALIVE;
          end
        endcase
      end
    end
  end

  assign o_frame     = r_frame;
  assign o_dead_done = r_dead_done;

endmodule

// File: rtl/sprite_anim_fetch.sv
// Multi-player animated sprite fetcher. Turns (player, x, y) pixel requests
// into sprite-sheet ROM addresses and returns colour plus transparency after
// 1 + ROM_LAT cycles. Optional feature macro: SPRITE_MIRROR_EN (horizontal
// mirroring of players facing left).
module sprite_anim_fetch
  import sprite_pkg::*;
#(
  parameter int              N_PLAYERS  = 2,
  parameter int              N_STATES   = N_STATES_DEF,
  parameter int              N_FRAMES   = N_FRAMES_DEF,
  parameter int              SPR_W      = SPR_W_DEF,
  parameter int              SPR_H      = SPR_H_DEF,
  parameter int              SHEET_W    = SHEET_W_DEF,
  parameter int              FRAME_DIV  = 8,
  parameter int              ROM_LAT    = 1,
  parameter int              ADDR_W     = 20,
  parameter logic [CLR_W-1:0] TRANSP_KEY = TRANSP_KEY_DEF,
  parameter int              PW         = idx_w(N_PLAYERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic [4*N_PLAYERS-1:0] state,
  input  logic [N_PLAYERS-1:0]   is_dead,
  input  logic [N_PLAYERS-1:0]   facing,
  sprite_anim_fetch_if.slave     bus,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [CLR_W-1:0]       rom_data,
  output logic [N_PLAYERS-1:0]   dead_done
);

  localparam int FW = idx_w(N_FRAMES);

  logic [FW-1:0]    w_frame [N_PLAYERS];
  logic [FW-1:0]    w_frame_sel;
  logic [3:0]       w_state_sel;
  logic             w_dead_sel;
  logic             w_oor;
  logic [31:0]      w_col;
  logic [31:0]      w_x_eff;
  logic [31:0]      w_addr32;
  logic [ADDR_W-1:0] w_addr;

  logic [ROM_LAT:0] r_v_pipe;
  logic [ROM_LAT:0] r_oor_pipe;
  logic [CLR_W-1:0] r_clr_hold;
  logic             r_transp_hold;
  logic [CLR_W-1:0] w_out_clr;
  logic             w_out_transp;

  genvar gi;

  // One animation counter per player
  generate
    for (gi = 0; gi < N_PLAYERS; gi++) begin : g_player
      sprite_anim_ctr #(
        .N_FRAMES  (N_FRAMES),
        .FRAME_DIV (FRAME_DIV),
        .FW        (FW)
      ) u_ctr (
        .clk          (clk),
        .rst          (rst),
        .i_frame_tick (frame_tick),
        .i_state      (state[4*gi +: 4]),
        .i_is_dead    (is_dead[gi]),
        .o_frame      (w_frame[gi]),
        .o_dead_done  (dead_done[gi])
      );
    end
  endgenerate

`ifdef SPRITE_MIRROR_EN
  logic w_facing_sel;
`else
  logic w_unused_facing;
  assign w_unused_facing = ^facing;
`endif

  // Select the requesting player's frame, pose and flags
  always_comb begin
    w_frame_sel = '0;
    w_state_sel = '0;
    w_dead_sel  = 1'b0;
`ifdef SPRITE_MIRROR_EN
    w_facing_sel = 1'b0;
`endif
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (32'(bus.req_player) == 32'(p)) begin
        w_frame_sel = w_frame[p];
        w_state_sel = state[4*p +: 4];
        w_dead_sel  = is_dead[p];
`ifdef SPRITE_MIRROR_EN
        w_facing_sel = facing[p];
`endif
      end
    end
  end

  // Range check and sheet address; the range check always uses the raw x
  always_comb begin
    w_oor = (32'(bus.req_x) >= 32'(SPR_W)) ||
            (32'(bus.req_y) >= 32'(SPR_H)) ||
            (32'(bus.req_player) >= 32'(N_PLAYERS));
    if (w_dead_sel) begin
      w_col = 32'(N_STATES);
    end else if (32'(w_state_sel) >= 32'(N_STATES)) begin
      w_col = 32'(N_STATES - 1);
    end else begin
      w_col = 32'(w_state_sel);
    end
`ifdef SPRITE_MIRROR_EN
    w_x_eff = w_facing_sel ? (32'(SPR_W - 1) - 32'(bus.req_x)) : 32'(bus.req_x);
`else
    w_x_eff = 32'(bus.req_x);
`endif
    w_addr32 = ((32'(bus.req_player) * 32'(N_FRAMES) + 32'(w_frame_sel)) * 32'(SPR_H)
                + 32'(bus.req_y)) * 32'(SHEET_W) + w_col * 32'(SPR_W) + w_x_eff;
    w_addr = w_oor ? '0 : w_addr32[ADDR_W-1:0];
  end

  // Stage 1: registered ROM address, updated on each accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
    end else if (bus.req_valid) begin
      rom_addr <= w_addr;
    end
  end

  // Valid / out-of-range delay line spanning stage 1 plus the ROM latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_pipe   <= '0;
      r_oor_pipe <= '0;
    end else begin
      r_v_pipe   <= {r_v_pipe[ROM_LAT-1:0], bus.req_valid};
      r_oor_pipe <= {r_oor_pipe[ROM_LAT-1:0], w_oor};
    end
  end

  assign w_out_transp = r_oor_pipe[ROM_LAT] | (rom_data == TRANSP_KEY);
  assign w_out_clr    = r_oor_pipe[ROM_LAT] ? '0 : rom_data;

  // Remember the last delivered pixel so outputs stay put between pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_hold    <= '0;
      r_transp_hold <= 1'b0;
    end else if (r_v_pipe[ROM_LAT]) begin
      r_clr_hold    <= w_out_clr;
      r_transp_hold <= w_out_transp;
    end
  end

  assign bus.pix_valid  = r_v_pipe[ROM_LAT];
  assign bus.pix_clr    = r_v_pipe[ROM_LAT] ? w_out_clr : r_clr_hold;
  assign bus.pix_transp = r_v_pipe[ROM_LAT] ? w_out_transp : r_transp_hold;

endmodule

// File: tb/tb_sprite_anim_fetch.sv
// Self-checking bench for sprite_anim_fetch: directed address table, animation
// sequences, randomized burst against a tick-count reference model.
module tb_sprite_anim_fetch;

  localparam int NP    = 2;
  localparam int NS    = 16;
  localparam int NF    = 4;
  localparam int SW    = 48;
  localparam int SH    = 67;
  localparam int PITCH = 816;
  localparam int FD    = 8;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic [7:0]  state;
  logic [1:0]  is_dead;
  logic [1:0]  facing;
  logic [19:0] rom_addr;
  logic [11:0] rom_data;
  logic [1:0]  dead_done;

  sprite_anim_fetch_if #(.PW(1)) bus ();

  sprite_anim_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .state      (state),
    .is_dead    (is_dead),
    .facing     (facing),
    .bus        (bus),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .dead_done  (dead_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite ROM: one cycle latency, word = low 12 address bits
  always @(posedge clk) rom_data <= rom_addr[11:0];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit oor; int unsigned addr; } exp_t;
  exp_t        exp_q[$];
  int          m_ticks [NP];
  bit          m_dead  [NP];
  bit          m_prev_dead [NP];
  int          m_prev_state [NP];
  bit          addr_pend;
  int unsigned addr_exp;
  int          pix_seen;
  int          last_clr;
  bit          last_transp;

  function automatic int m_frame(input int p);
    int f;
    f = m_ticks[p] / FD;
    if (m_dead[p]) return (f > NF - 1) ? NF - 1 : f;
    return f % NF;
  endfunction

  function automatic bit m_done(input int p);
    return m_dead[p] && (m_ticks[p] / FD >= NF - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        m_ticks[p] = 0; m_dead[p] = 0; m_prev_dead[p] = 0; m_prev_state[p] = 0;
      end
      exp_q.delete();
      addr_pend   = 0;
      last_clr    = 0;
      last_transp = 0;
    end else begin
      addr_pend = 0;
      if (bus.req_valid) begin
        exp_t e;
        int p, x, y, st, col, xe;
        p  = int'(bus.req_player);
        x  = int'(bus.req_x);
        y  = int'(bus.req_y);
        e.oor = (x >= SW) || (y >= SH) || (p >= NP);
        e.addr = 0;
        if (!e.oor) begin
          st  = int'(state[4*p +: 4]);
          col = is_dead[p] ? NS : ((st >= NS) ? NS - 1 : st);
          xe  = x;
`ifdef SPRITE_MIRROR_EN
          if (facing[p]) xe = SW - 1 - x;
`endif
          e.addr = (((p * NF + m_frame(p)) * SH + y) * PITCH + col * SW + xe) & 32'hFFFFF;
        end
        exp_q.push_back(e);
        addr_pend = 1;
        addr_exp  = e.addr;
      end
      for (int p = 0; p < NP; p++) begin
        int st;
        st = int'(state[4*p +: 4]);
        if (is_dead[p] != m_prev_dead[p]) begin
          m_dead[p]  = is_dead[p];
          m_ticks[p] = 0;
        end else if (!m_dead[p] && st != m_prev_state[p]) begin
          m_ticks[p] = 0;
        end else if (frame_tick && m_ticks[p] < 100000) begin
          m_ticks[p]++;
        end
        m_prev_dead[p]  = is_dead[p];
        m_prev_state[p] = st;
      end
    end
  end

  // Output monitor, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (addr_pend) chk("rom_addr", rom_addr, addr_exp);
      if (bus.pix_valid) begin
        pix_seen++;
        if (exp_q.size() == 0) begin
          chk("pix_spurious", bus.pix_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          last_clr    = e.oor ? 0 : int'(e.addr & 32'hFFF);
          last_transp = e.oor || ((e.addr & 32'hFFF) == 32'hF0F);
          chk("pix_clr", bus.pix_clr, last_clr);
          chk("pix_transp", bus.pix_transp, last_transp);
        end
      end else begin
        chk("hold_clr", bus.pix_clr, last_clr);
        chk("hold_transp", bus.pix_transp, last_transp);
      end
      for (int p = 0; p < NP; p++) chk("dead_done", dead_done[p], m_done(p));
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic do_req(input int p, input int x, input int y, input int unsigned exp_a,
                        input string name);
    bus.req_valid  = 1'b1;
    bus.req_player = 1'(p);
    bus.req_x      = 6'(x);
    bus.req_y      = 7'(y);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk(name, rom_addr, exp_a);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          p;
    int          st;
    int          x;
    int          y;
    int unsigned exp_addr;
    int          exp_clr;
    bit          exp_transp;
    string       name;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    tbl[0] = '{1, 3,  5, 10, 226997, 12'h6B5, 1'b0, "t_p1_s3"};
    tbl[1] = '{0, 0,  0,  0,      0, 12'h000, 1'b0, "t_origin"};
    tbl[2] = '{0, 12, 15, 4,   3855, 12'hF0F, 1'b1, "t_key"};
    tbl[3] = '{0, 0, 50,  0,      0, 12'h000, 1'b1, "t_x50"};
    tbl[4] = '{0, 0, 48,  0,      0, 12'h000, 1'b1, "t_x48"};
    tbl[5] = '{0, 0, 47, 66,  53903, 12'h28F, 1'b0, "t_corner"};
    tbl[6] = '{1, 15, 0, 67,      0, 12'h000, 1'b1, "t_y67"};
    tbl[7] = '{1, 15, 47, 0, 219455, 12'h93F, 1'b0, "t_p1_s15"};

    rst = 1'b1; frame_tick = 1'b0; state = '0; is_dead = '0; facing = '0;
    bus.req_valid = 1'b0; bus.req_player = '0; bus.req_x = '0; bus.req_y = '0;
    repeat (3) @(negedge clk);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_pix_valid", bus.pix_valid, 0);
    chk("reset_dead_done", dead_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed address/colour table
    for (int i = 0; i < 8; i++) begin
      state[4*tbl[i].p +: 4] = 4'(tbl[i].st);
      do_req(tbl[i].p, tbl[i].x, tbl[i].y, tbl[i].exp_addr, tbl[i].name);
      @(negedge clk);
      chk({tbl[i].name, "_valid"}, bus.pix_valid, 1);
      chk({tbl[i].name, "_clr"}, bus.pix_clr, tbl[i].exp_clr);
      chk({tbl[i].name, "_transp"}, bus.pix_transp, tbl[i].exp_transp);
      @(negedge clk);
    end

    // Death animation on player 0
    state = '0;
    @(negedge clk);
    is_dead[0] = 1'b1;
    do_req(0, 0, 0, 768, "dead_col");
    tick_n(32);
    chk("dead_done_after32", dead_done[0], 1);
    do_req(0, 0, 0, 164784, "dead_last_frame");
    tick_n(8);
    chk("dead_done_hold", dead_done[0], 1);
    do_req(0, 0, 0, 164784, "dead_frame_hold");
    is_dead[0] = 1'b0;
    @(negedge clk);
    chk("respawn_done", dead_done[0], 0);

    // Alive looping and pose-change priority
    state[3:0] = 4'd2;
    @(negedge clk);
    tick_n(8);
    do_req(0, 0, 0, 54768, "alive_frame1");
    tick_n(7);
    frame_tick = 1'b1;
    state[3:0] = 4'd5;
    @(negedge clk);
    frame_tick = 1'b0;
    do_req(0, 0, 0, 240, "chg_beats_tick");

    // Mirroring
    state[3:0] = 4'd0;
    @(negedge clk);
    facing[0] = 1'b1;
`ifdef SPRITE_MIRROR_EN
    do_req(0, 0, 0, 47, "mirror_on");
`else
    do_req(0, 0, 0, 0, "mirror_ignored");
`endif
    facing[0] = 1'b0;
    do_req(0, 0, 0, 0, "mirror_off");
    repeat (3) @(negedge clk);

    // Randomized back-to-back burst
    base = pix_seen;
    for (int c = 0; c < 100; c++) begin
      bus.req_valid  = 1'b1;
      bus.req_player = 1'($urandom_range(0, 1));
      bus.req_x      = 6'($urandom_range(0, 63));
      bus.req_y      = 7'($urandom_range(0, 127));
      frame_tick     = ($urandom_range(0, 2) == 0);
      facing         = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) state[4*$urandom_range(0, 1) +: 4] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) is_dead[$urandom_range(0, 1)] ^= 1'b1;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    frame_tick    = 1'b0;
    repeat (4) @(negedge clk);
    chk("burst_count", pix_seen - base, 100);

    // Reset in the middle of a burst
    for (int c = 0; c < 10; c++) begin
      bus.req_valid  = 1'b1;
      bus.req_player = 1'($urandom_range(0, 1));
      bus.req_x      = 6'($urandom_range(0, 47));
      bus.req_y      = 7'($urandom_range(0, 66));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pix_valid", bus.pix_valid, 0);
    for (int c = 0; c < 5; c++) begin
      bus.req_player = 1'($urandom_range(0, 1));
      bus.req_x      = 6'($urandom_range(0, 63));
      bus.req_y      = 7'($urandom_range(0, 127));
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
